// File: rtl/gunshot_event_qualifier_if.sv
// gunshot_event_qualifier_if: valid/ready channel carrying one qualified gunshot event
interface gunshot_event_qualifier_if #(parameter int TS_WIDTH = 32);
  logic evt_valid;
  logic evt_ready;
  logic [2:0] evt_dir;
  logic [TS_WIDTH-1:0] evt_timestamp;
  modport master(output evt_valid, evt_dir, evt_timestamp, input evt_ready);
  modport slave(input evt_valid, evt_dir, evt_timestamp, output evt_ready);
endinterface

// File: rtl/gunshot_event_qualifier.sv
// gunshot_event_qualifier: confirms stable-direction detections, timestamps them, then holds off
module gunshot_event_qualifier #(
  parameter int CONFIRM_CYCLES = 4,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int TS_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic det_in,
  input  logic [2:0] dir_in,
  gunshot_event_qualifier_if.master evt,
  output logic [CNT_WIDTH-1:0] evt_count,
  output logic [CNT_WIDTH-1:0] evt_dropped,
  output logic busy
);
  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CW-1:0] CONF = CW'(CONFIRM_CYCLES);
  typedef enum logic [1:0] {IDLE, CONFIRM, REPORT, HOLDOFF} state_t;
  state_t state;
  logic [TS_WIDTH-1:0] ts, cand_ts, nxt_ts;
  logic [2:0] cand_dir, nxt_dir;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [HW-1:0] hold;
  logic det_prev, vdet, onset, keep;
  assign vdet = det_in && dir_in <= 3'd5;
  assign onset = det_in && !det_prev;
  // IDLE and a direction change in CONFIRM both start a fresh candidate run
  assign keep = state == CONFIRM && dir_in == cand_dir;
  assign nxt_dir = keep ? cand_dir : dir_in;
  assign nxt_ts = keep ? cand_ts : ts;
  assign nxt_cnt = keep ? cnt + 1'b1 : CW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ts <= '0;
      cand_ts <= '0;
      cand_dir <= '0;
      cnt <= '0;
      hold <= '0;
      det_prev <= 1'b0;
      evt.evt_valid <= 1'b0;
      evt.evt_dir <= '0;
      evt.evt_timestamp <= '0;
      evt_count <= '0;
      evt_dropped <= '0;
      busy <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      det_prev <= det_in;
      if (onset && (state == REPORT || state == HOLDOFF) && !(&evt_dropped))
        evt_dropped <= evt_dropped + 1'b1;
      unique case (state)
        IDLE, CONFIRM:
          if (vdet) begin
            cand_dir <= nxt_dir;
            cand_ts <= nxt_ts;
            cnt <= nxt_cnt;
            busy <= 1'b1;
            state <= nxt_cnt == CONF ? REPORT : CONFIRM;
            if (nxt_cnt == CONF) begin
              evt.evt_valid <= 1'b1;
              evt.evt_dir <= nxt_dir;
              evt.evt_timestamp <= nxt_ts;
            end
          end else begin
            state <= IDLE;
            cnt <= '0;
            busy <= 1'b0;
          end
        REPORT:
          if (evt.evt_ready) begin
            evt.evt_valid <= 1'b0;
            hold <= HW'(HOLDOFF_CYCLES);
            state <= HOLDOFF;
            if (!(&evt_count)) evt_count <= evt_count + 1'b1;
          end
        HOLDOFF:
          // a detection still present at expiry keeps us parked until it ends
          if (|hold) hold <= hold - 1'b1;
          else if (!det_in) begin
            state <= IDLE;
            busy <= 1'b0;
          end
      endcase
    end
  end
endmodule

// File: doc/gunshot_event_qualifier.md
Name: gunshot_event_qualifier

Overview:
- Downstream stage of the 6-mic gunshot detector; consumes its per-cycle `gunshot_detected`/`direction` outputs.
- Qualifies a detection only if it persists with a stable direction, then timestamps it.
- Presents the event on a valid/ready interface to the host/logging stage.
- After each reported event, enforces a hold-off window, counting suppressed detections.

Parameters:
- CONFIRM_CYCLES, 4, consecutive same-direction detect cycles required to qualify (>=1)
- HOLDOFF_CYCLES, 1000, minimum cycles after handshake before re-arming (>=1)
- TS_WIDTH, 32, timestamp counter width
- CNT_WIDTH, 16, event/drop counter width

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- det_in  input  1  gunshot_detected from detector
- dir_in  input  3  direction from detector; valid values 0..5
- evt_valid  output  1  qualified event available
- evt_ready  input  1  consumer accepts event
- evt_dir  output  3  direction of qualified event
- evt_timestamp  output  TS_WIDTH  ts value at first cycle of qualifying run
- evt_count  output  CNT_WIDTH  accepted events, saturating
- evt_dropped  output  CNT_WIDTH  suppressed detection onsets, saturating
- busy  output  1  high when state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled at posedge clk.
- Reset values: state=IDLE, ts=0, evt_valid=0, evt_dir=0, evt_timestamp=0, evt_count=0, evt_dropped=0, busy=0, internal confirm/holdoff counters=0, det_prev=0.
- Reset has priority over all other activity, including mid-REPORT (evt_valid low the cycle after the reset edge) and mid-HOLDOFF.
- ts: free-running, +1 every non-reset cycle, wraps modulo 2^TS_WIDTH.
- Valid detect sample: det_in=1 and dir_in<=5. det_in=1 with dir_in 6 or 7 is treated as det_in=0.
- det_prev registers det_in every cycle. An onset is det_in=1 with det_prev=0.
- IDLE:
  - Valid detect: cand_dir=dir_in, cand_ts=ts, cnt=1.
  - If CONFIRM_CYCLES=1, go to REPORT; otherwise go to CONFIRM.
- CONFIRM:
  - Valid detect with dir_in==cand_dir: cnt+1. When cnt+1==CONFIRM_CYCLES, go to REPORT.
  - Valid detect with a different dir: restart with cand_dir=dir_in, cand_ts=ts, cnt=1; stay in CONFIRM.
  - Otherwise (no valid detect): return to IDLE; no event, no counter change.
- Latency: detection first sampled at edge k ⇒ evt_valid=1 after edge k+CONFIRM_CYCLES-1.
- REPORT:
  - evt_valid=1; evt_dir=cand_dir; evt_timestamp=cand_ts.
  - evt_dir and evt_timestamp stay stable until handshake. No timeout; stall is unbounded.
  - Handshake (evt_valid & evt_ready at an edge): evt_valid=0 next cycle, evt_count+1 (saturate at all-ones), holdoff cnt=HOLDOFF_CYCLES, go to HOLDOFF.
  - evt_ready while evt_valid=0 has no effect.
- HOLDOFF:
  - Decrement holdoff cnt each cycle until 0.
  - Return to IDLE only when cnt==0 and det_in==0. Otherwise remain in HOLDOFF with cnt held at 0.
  - A sustained detection therefore never re-triggers.
- Drops: each onset sampled while state is REPORT or HOLDOFF increments evt_dropped (saturating). det_in held high counts once.
- Simultaneous events:
  - Handshake and onset at the same edge in REPORT: both take effect.
  - Onset at the edge HOLDOFF exits to IDLE: impossible by the exit rule (det_in must be 0).
- evt_dir and evt_timestamp hold their last values outside REPORT.

Test Plan:
(All with CONFIRM_CYCLES=4, HOLDOFF_CYCLES=8.)
1. Basic event: det_in=1, dir_in=3 for 4 cycles starting at ts=10, evt_ready=1 → evt_valid high for exactly 1 cycle after the 4th edge with evt_dir=3, evt_timestamp=10; evt_count=1; busy high through HOLDOFF.
2. Short burst and invalid direction: det_in=1 dir=2 for 3 cycles then 0 → no evt_valid, evt_count=0, back to IDLE. det_in=1 dir_in=6 for 10 cycles → no event, busy stays 0.
3. Direction change: dir sequence 2,2,5,5,5,5 (det_in=1) with the first 5 at ts=40 → event evt_dir=5, evt_timestamp=40, asserted after the 6th edge.
4. Backpressure and drops: qualify an event, hold evt_ready=0 for 20 cycles while pulsing det_in 0→1 twice → evt_valid, evt_dir, evt_timestamp stable for all 20 cycles; evt_dropped=2; after evt_ready=1, evt_count=1.
5. Hold-off behaviour:
   - det_in held high continuously for 50 cycles after a handshake → one event only; evt_dropped=0; HOLDOFF persists past 8 cycles.
   - After det_in=0 for 1 cycle → IDLE; then 4 detect cycles produce a second event, evt_count=2.
6. Reset and saturation:
   - reset asserted for 1 cycle in REPORT → evt_valid=0, evt_count=0, evt_dropped=0, state IDLE after the edge.
   - Preload by forcing ts near 2^TS_WIDTH-1 → timestamp wraps to 0; an event captures the wrapped value correctly.
